// File: rtl/led_arb_pkg.sv
// Shared state encoding and default widths for the LED bank arbiter.
package led_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWNED = 2'b01,
    HOLD  = 2'b10
  } arb_state_t;

  localparam int LED_ARB_NLEDS   = 8;
  localparam int LED_ARB_NREQ    = 4;
  localparam int LED_ARB_CTRBITS = 24;

endpackage

// File: rtl/led_arb_prio.sv
// Fixed-priority encoder: lowest set bit of (req & mask) wins.
// Latency: combinational. Backpressure: none.
// Flow control: none, pure function of its inputs.
module led_arb_prio
  import led_arb_pkg::*;
#(
  parameter int NREQ = LED_ARB_NREQ,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  output logic            any,
  output logic [IW-1:0]   idx,
  output logic [NREQ-1:0] onehot
);

  logic [NREQ-1:0] masked;

  assign masked = req & mask;
  assign any    = |masked;

  // Scan from the top down so the lowest index is the last one written.
  always_comb begin
    idx    = '0;
    onehot = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (masked[i]) begin
        idx       = IW'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_arbiter.sv
// Fixed-priority LED bank arbiter with minimum dwell; optional PWM dimming under LED_ARB_DIM_EN.
// Latency: one cycle from selected pattern to registered o_leds.
// Backpressure: none; requests are levels and losers simply wait.
module led_arbiter
  import led_arb_pkg::*;
#(
  parameter int          NLEDS     = LED_ARB_NLEDS,
  parameter int          NREQ      = LED_ARB_NREQ,
  parameter int          CTRBITS   = LED_ARB_CTRBITS,
  parameter int unsigned MIN_DWELL = 10_000_000
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic [NLEDS-1:0]      i_default_leds,
  input  logic [NREQ-1:0]       i_req,
  input  logic [NREQ*NLEDS-1:0] i_req_leds,
`ifdef LED_ARB_DIM_EN
  input  logic [2:0]            i_dim,
`endif
  output logic [NREQ-1:0]       o_grant,
  output logic                  o_busy,
  output logic [NLEDS-1:0]      o_leds
);

  localparam int                IW         = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CTRBITS-1:0] DWELL_LOAD = CTRBITS'(MIN_DWELL - 1);

  arb_state_t         state_q, state_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [CTRBITS-1:0] ctr_q, ctr_d, ctr_dec;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic               busy_q;
  logic [NLEDS-1:0]   pat_q, pat_d;
  logic [NLEDS-1:0]   owner_leds;
  logic               owner_req;
  logic               ctr_zero;
  logic [NREQ-1:0]    all_mask, pre_mask;
  logic               all_any, pre_any;
  logic [IW-1:0]      all_idx, pre_idx;
  logic [NREQ-1:0]    all_onehot, pre_onehot;

  assign all_mask = '1;

  // Only requesters strictly above the current owner may preempt it.
  always_comb begin
    pre_mask = '0;
    for (int j = 0; j < NREQ; j++) begin
      pre_mask[j] = (j < int'(owner_q));
    end
  end

  led_arb_prio #(.NREQ(NREQ), .IW(IW)) u_prio_all (
    .req    (i_req),
    .mask   (all_mask),
    .any    (all_any),
    .idx    (all_idx),
    .onehot (all_onehot)
  );

  led_arb_prio #(.NREQ(NREQ), .IW(IW)) u_prio_pre (
    .req    (i_req),
    .mask   (pre_mask),
    .any    (pre_any),
    .idx    (pre_idx),
    .onehot (pre_onehot)
  );

  // Only the owner's slice is ever muxed in, so junk on other slices stays out.
  assign owner_leds = i_req_leds[owner_q*NLEDS +: NLEDS];
  assign owner_req  = i_req[owner_q];
  assign ctr_zero   = (ctr_q == '0);
  assign ctr_dec    = ctr_zero ? '0 : ctr_q - 1'b1;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    grant_d = grant_q;
    ctr_d   = ctr_dec;
    pat_d   = pat_q;
    unique case (state_q)
      IDLE: begin
        pat_d = i_default_leds;
        if (all_any) begin
          owner_d = all_idx;
          grant_d = all_onehot;
          ctr_d   = DWELL_LOAD;
          state_d = OWNED;
        end
      end
      OWNED: begin
        pat_d = owner_leds;
        if (ctr_zero && pre_any) begin
          owner_d = pre_idx;
          grant_d = pre_onehot;
          ctr_d   = DWELL_LOAD;
        end else if (!owner_req && ctr_zero) begin
          grant_d = '0;
          state_d = IDLE;
        end else if (!owner_req) begin
          grant_d = '0;
          pat_d   = pat_q;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (owner_req) begin
          grant_d = NREQ'(1) << owner_q;
          state_d = OWNED;
        end else if (ctr_zero) begin
          state_d = IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ctr_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      pat_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ctr_q   <= ctr_d;
      grant_q <= grant_d;
      busy_q  <= (state_d != IDLE);
      pat_q   <= pat_d;
    end
  end

  assign o_grant = grant_q;
  assign o_busy  = busy_q;

`ifdef LED_ARB_DIM_EN
  logic [2:0]       pwm_q;
  logic [NLEDS-1:0] leds_q;

  // pat_q keeps the undimmed pattern so a frozen HOLD image stays intact.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pwm_q  <= '0;
      leds_q <= '0;
    end else begin
      pwm_q  <= pwm_q + 3'd1;
      leds_q <= pat_d & {NLEDS{pwm_q >= i_dim}};
    end
  end

  assign o_leds = leds_q;
`else
  assign o_leds = pat_q;
`endif

endmodule
